// File: rtl/nqcpu_pkg.sv
// Shared types and constants for the nqcpu datapath stages: memory-stage
// state encoding, control-word width and bus byte-lane enables.
package nqcpu_pkg;

  localparam int CTRL_W = 33;

  localparam logic [1:0] BE_LO = 2'b01;
  localparam logic [1:0] BE_HI = 2'b10;
  localparam logic [1:0] BE_W  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    DONE = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the 16-bit little-endian data bus:
// byte enables and store lanes per access, and load-lane selection.
module mem_lane_align
  import nqcpu_pkg::*;
(
  input  logic        addr_lsb,
  input  logic        byte_op,
  input  logic        phase,
  input  logic [15:0] wdata,
  input  logic [15:0] rdata,
  output logic [1:0]  be,
  output logic [15:0] wdata_bus,
  output logic [7:0]  lane_byte,
  output logic [15:0] load_word
);

  // A misaligned word is two byte accesses: low byte on the odd lane first,
  // then the high byte on the even lane of the next halfword.
  always_comb begin
    be        = BE_W;
    wdata_bus = wdata;
    if (byte_op) begin
      be        = addr_lsb ? BE_HI : BE_LO;
      wdata_bus = {wdata[7:0], wdata[7:0]};
    end else if (addr_lsb && !phase) begin
      be        = BE_HI;
      wdata_bus = {wdata[7:0], 8'h00};
    end else if (addr_lsb) begin
      be        = BE_LO;
      wdata_bus = {8'h00, wdata[15:8]};
    end
  end

  assign lane_byte = (be == BE_HI) ? rdata[15:8] : rdata[7:0];
  assign load_word = (be == BE_W) ? rdata : {8'h00, lane_byte};

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: runs one or two req/ack bus transactions per op and
// returns load data. Define MEM_STAGE_MISALIGN_SPLIT_EN to split misaligned words.
module mem_stage
  import nqcpu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [15:0]       imm_in,
  input  logic [15:0]       pc_in,
  input  logic [15:0]       addr_in,
  input  logic [15:0]       wdata_in,
  input  logic              rd_b,
  input  logic              rd_w,
  input  logic              wr_b,
  input  logic              wr_w,
  output logic              ready,
  output logic              fault,
  output logic [15:0]       rdata_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [15:0]       imm_out,
  output logic [15:0]       pc_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [15:0]       mem_addr,
  output logic [1:0]        mem_be,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata
);

`ifdef MEM_STAGE_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif
  localparam int TO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  mem_state_t state, state_next;

  logic [CTRL_W-1:0] ctrl_p0;
  logic [15:0]       imm_p0, pc_p0, addr_p0, wdata_p0, rdata_p0;
  logic [7:0]        lo_p0;
  logic              byte_p0, write_p0, load_p0, split_p0, fault_p0;
  logic [TO_W-1:0]   wait_cnt;

  logic [2:0]  nflags;
  logic        odd_word_in, bad_in, start;
  logic        acc, phase, last_acc, timed_out;
  logic [1:0]  lane_be;
  logic [15:0] lane_wdata, load_word;
  logic [7:0]  lane_byte;

  assign nflags      = 3'(rd_b) + 3'(rd_w) + 3'(wr_b) + 3'(wr_w);
  assign odd_word_in = (rd_w | wr_w) & addr_in[0];
  assign bad_in      = (nflags > 3'd1) | (odd_word_in & ~SPLIT_EN);
  assign start       = (state == IDLE) & en;

  assign acc       = (state == ACC1) | (state == ACC2);
  assign phase     = (state == ACC2);
  assign last_acc  = phase | ~split_p0;
  assign timed_out = (ACK_TIMEOUT != 0) & acc & ~mem_ack & (wait_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (en) state_next = (nflags == 3'd1 && !bad_in) ? ACC1 : DONE;
      ACC1: begin
        if (mem_ack)        state_next = split_p0 ? ACC2 : DONE;
        else if (timed_out) state_next = DONE;
      end
`ifdef MEM_STAGE_MISALIGN_SPLIT_EN
      ACC2: if (mem_ack || timed_out) state_next = DONE;
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Op capture (p0): control and visible outputs are reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_p0  <= '0;
      imm_p0   <= '0;
      pc_p0    <= '0;
      byte_p0  <= 1'b0;
      write_p0 <= 1'b0;
      load_p0  <= 1'b0;
      split_p0 <= 1'b0;
      fault_p0 <= 1'b0;
      rdata_p0 <= '0;
      wait_cnt <= '0;
    end else begin
      if (start) begin
        ctrl_p0  <= ctrl_in;
        imm_p0   <= imm_in;
        pc_p0    <= pc_in;
        byte_p0  <= rd_b | wr_b;
        write_p0 <= wr_b | wr_w;
        load_p0  <= rd_b | rd_w;
        split_p0 <= odd_word_in & SPLIT_EN;
        fault_p0 <= bad_in;
        if (nflags == 3'd1 && odd_word_in && !SPLIT_EN) rdata_p0 <= '0;
      end
      if (acc) begin
        if (mem_ack) begin
          wait_cnt <= '0;
          if (last_acc && load_p0) rdata_p0 <= split_p0 ? {lane_byte, lo_p0} : load_word;
        end else if (timed_out) begin
          wait_cnt <= '0;
          fault_p0 <= 1'b1;
          rdata_p0 <= '0;
        end else begin
          wait_cnt <= wait_cnt + TO_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      addr_p0  <= addr_in;
      wdata_p0 <= wdata_in;
    end
    if (state == ACC1 && mem_ack) lo_p0 <= lane_byte;
  end

  mem_lane_align u_align (
    .addr_lsb  (addr_p0[0]),
    .byte_op   (byte_p0),
    .phase     (phase),
    .wdata     (wdata_p0),
    .rdata     (mem_rdata),
    .be        (lane_be),
    .wdata_bus (lane_wdata),
    .lane_byte (lane_byte),
    .load_word (load_word)
  );

  // Bus outputs derive from state so reset drops the request at once
  assign mem_req   = acc;
  assign mem_we    = acc & write_p0;
  assign mem_addr  = acc ? (phase ? addr_p0 + 16'd1 : addr_p0) : '0;
  assign mem_be    = acc ? lane_be : '0;
  assign mem_wdata = (acc && write_p0) ? lane_wdata : '0;

  assign ready     = (state == DONE);
  assign fault     = ready & fault_p0;
  assign rdata_out = rdata_p0;
  assign ctrl_out  = ctrl_p0;
  assign imm_out   = imm_p0;
  assign pc_out    = pc_p0;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: byte-addressed memory responder plus a
// reference model of ops on a byte image; directed and randomized scenarios.
`timescale 1ns/1ps
module tb_mem_stage;
  import nqcpu_pkg::*;

`ifdef MEM_STAGE_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  localparam logic [3:0] RD_B = 4'b1000, RD_W = 4'b0100, WR_B = 4'b0010, WR_W = 4'b0001;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [CTRL_W-1:0] ctrl_in = '0, ctrl_out;
  logic [15:0] imm_in = '0, pc_in = '0, addr_in = '0, wdata_in = '0;
  logic rd_b = 1'b0, rd_w = 1'b0, wr_b = 1'b0, wr_w = 1'b0;
  logic ready, fault, mem_req, mem_we;
  logic [15:0] rdata_out, imm_out, pc_out, mem_addr, mem_wdata;
  logic [1:0] mem_be;
  logic mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_stage #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ctrl_in(ctrl_in), .imm_in(imm_in),
    .pc_in(pc_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .rd_b(rd_b), .rd_w(rd_w), .wr_b(wr_b), .wr_w(wr_w),
    .ready(ready), .fault(fault), .rdata_out(rdata_out), .ctrl_out(ctrl_out),
    .imm_out(imm_out), .pc_out(pc_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Memory responder: byte image, acks after ack_wait extra request cycles
  typedef struct packed {
    logic [15:0] addr;
    logic [1:0]  be;
    logic        we;
    logic [15:0] wdata;
  } acc_t;
  acc_t acc_q[$];
  logic [7:0] mem [logic [15:0]];
  logic [7:0] ref_mem [logic [15:0]];
  logic [15:0] b0, b1;
  int req_cycles = 0, req_hi_cnt = 0;
  int ack_wait = 0;
  logic ack_en = 1'b1;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] rd_byte(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : init_byte(a);
  endfunction
  function automatic logic [7:0] ref_byte(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ack = 1'b0;
      req_cycles = 0;
    end else begin
      mem_ack = 1'b0;
      mem_rdata = 16'($urandom);
      if (mem_req) begin
        req_hi_cnt++;
        if (ack_en && req_cycles >= ack_wait) begin
          b0 = {mem_addr[15:1], 1'b0};
          b1 = {mem_addr[15:1], 1'b1};
          mem_rdata = {rd_byte(b1), rd_byte(b0)};
          if (mem_we && mem_be[0]) mem[b0] = mem_wdata[7:0];
          if (mem_we && mem_be[1]) mem[b1] = mem_wdata[15:8];
          acc_q.push_back('{mem_addr, mem_be, mem_we, mem_wdata});
          mem_ack = 1'b1;
          req_cycles = 0;
        end else begin
          req_cycles++;
        end
      end else begin
        req_cycles = 0;
      end
    end
  end

  int n_checks = 0, n_pass = 0;
  logic [15:0] exp_rdata = '0;

  // Reference model: op semantics on the byte image, latency from wait states
  task automatic model_op(input logic [3:0] fl, input logic [15:0] a, input logic [15:0] wd,
                          input int w, output int e_lat, output logic e_fault, output int e_nacc);
    int nf;
    logic word;
    logic [15:0] a1;
    nf = $countones(fl);
    word = fl[2] | fl[0];
    a1 = a + 16'd1;
    e_lat = 1; e_fault = 1'b0; e_nacc = 0;
    if (nf > 1) e_fault = 1'b1;
    else if (nf == 1) begin
      if (word && a[0] && !SPLIT) begin
        e_fault = 1'b1;
        exp_rdata = '0;
      end else begin
        e_nacc = (word && a[0]) ? 2 : 1;
        e_lat = (e_nacc == 2) ? 2 * w + 3 : w + 2;
        case (fl)
          RD_B: exp_rdata = {8'h00, ref_byte(a)};
          RD_W: exp_rdata = {ref_byte(a1), ref_byte(a)};
          WR_B: ref_mem[a] = wd[7:0];
          default: begin ref_mem[a] = wd[7:0]; ref_mem[a1] = wd[15:8]; end
        endcase
      end
    end
  endtask

  task automatic run_op(input logic [3:0] fl, input logic [15:0] a, input logic [15:0] wd,
                        output int lat, output logic f, output logic got);
    @(negedge clk);
    {rd_b, rd_w, wr_b, wr_w} = fl;
    addr_in = a; wdata_in = wd; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    got = 1'b0; lat = 0; f = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      if (ready === 1'b1) begin got = 1'b1; lat = i; f = fault; break; end
      @(posedge clk); #1;
    end
    if (got) begin @(posedge clk); #1; end
  endtask

  int lat, e_lat, e_nacc, rbase, abase;
  logic f, got, e_fault;
  acc_t a0, a1;

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; rd_w = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({mem_req, mem_we, ready, fault, mem_be} !== 6'b0)
      $display("FAIL reset_ctrl got %b want 000000", {mem_req, mem_we, ready, fault, mem_be});
    else n_pass++;
    n_checks++;
    if ({rdata_out, imm_out, pc_out, mem_addr, mem_wdata} !== 80'h0)
      $display("FAIL reset_data got %h want 0", {rdata_out, imm_out, pc_out, mem_addr, mem_wdata});
    else n_pass++;
    n_checks++;
    if (ctrl_out !== '0) $display("FAIL reset_ctrl_out got %h want 0", ctrl_out); else n_pass++;
    en = 1'b0; rd_w = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_noop;
    pc_in = 16'h0010; imm_in = 16'h7E01; ctrl_in = {1'b1, 32'hC0FFEE42};
    rbase = req_hi_cnt;
    model_op(4'b0000, 16'h0000, 16'h0000, 0, e_lat, e_fault, e_nacc);
    run_op(4'b0000, 16'h0000, 16'h0000, lat, f, got);
    n_checks++; if (!got || lat != 1) $display("FAIL noop_lat got %0d want 1", lat); else n_pass++;
    n_checks++; if (f !== 1'b0) $display("FAIL noop_fault got %b want 0", f); else n_pass++;
    n_checks++; if (pc_out !== 16'h0010) $display("FAIL noop_pc got %h want 0010", pc_out); else n_pass++;
    n_checks++;
    if ({ctrl_out, imm_out} !== {1'b1, 32'hC0FFEE42, 16'h7E01})
      $display("FAIL noop_pass got %h want %h", {ctrl_out, imm_out}, {1'b1, 32'hC0FFEE42, 16'h7E01});
    else n_pass++;
    n_checks++; if (req_hi_cnt != rbase) $display("FAIL noop_req got %0d want 0", req_hi_cnt - rbase); else n_pass++;
  endtask

  task automatic test_aligned_load;
    ack_wait = 0;
    model_op(WR_W, 16'h0040, 16'hBEEF, 0, e_lat, e_fault, e_nacc);
    run_op(WR_W, 16'h0040, 16'hBEEF, lat, f, got);
    ack_wait = 2;
    rbase = req_hi_cnt; abase = acc_q.size();
    model_op(RD_W, 16'h0040, 16'h0000, 2, e_lat, e_fault, e_nacc);
    run_op(RD_W, 16'h0040, 16'h0000, lat, f, got);
    a0 = (acc_q.size() > abase) ? acc_q[abase] : '0;
    n_checks++; if (!got || lat != 4) $display("FAIL wload_lat got %0d want 4", lat); else n_pass++;
    n_checks++; if (rdata_out !== 16'hBEEF) $display("FAIL wload_data got %h want beef", rdata_out); else n_pass++;
    n_checks++; if (acc_q.size() - abase != 1) $display("FAIL wload_nacc got %0d want 1", acc_q.size() - abase); else n_pass++;
    n_checks++;
    if ({a0.addr, a0.be, a0.we} !== {16'h0040, 2'b11, 1'b0})
      $display("FAIL wload_bus got %h/%b/%b want 0040/11/0", a0.addr, a0.be, a0.we);
    else n_pass++;
    n_checks++; if (req_hi_cnt - rbase != 3) $display("FAIL wload_req got %0d want 3", req_hi_cnt - rbase); else n_pass++;
  endtask

  task automatic test_byte_store;
    ack_wait = 1;
    abase = acc_q.size();
    model_op(WR_B, 16'h0041, 16'h12A5, 1, e_lat, e_fault, e_nacc);
    run_op(WR_B, 16'h0041, 16'h12A5, lat, f, got);
    a0 = (acc_q.size() > abase) ? acc_q[abase] : '0;
    n_checks++; if (!got || lat != 3) $display("FAIL bstore_lat got %0d want 3", lat); else n_pass++;
    n_checks++; if (acc_q.size() - abase != 1) $display("FAIL bstore_nacc got %0d want 1", acc_q.size() - abase); else n_pass++;
    n_checks++;
    if ({a0.addr, a0.be, a0.we, a0.wdata} !== {16'h0041, 2'b10, 1'b1, 16'hA5A5})
      $display("FAIL bstore_bus got %h/%b/%b/%h want 0041/10/1/a5a5", a0.addr, a0.be, a0.we, a0.wdata);
    else n_pass++;
    n_checks++; if (rd_byte(16'h0041) !== 8'hA5) $display("FAIL bstore_mem got %h want a5", rd_byte(16'h0041)); else n_pass++;
    n_checks++; if (rdata_out !== 16'hBEEF) $display("FAIL bstore_hold got %h want beef", rdata_out); else n_pass++;
  endtask

  task automatic test_split;
    ack_wait = 0;
    model_op(WR_W, 16'hFFFE, 16'h3400, 0, e_lat, e_fault, e_nacc);
    run_op(WR_W, 16'hFFFE, 16'h3400, lat, f, got);
    model_op(WR_W, 16'h0000, 16'h0012, 0, e_lat, e_fault, e_nacc);
    run_op(WR_W, 16'h0000, 16'h0012, lat, f, got);
    rbase = req_hi_cnt; abase = acc_q.size();
    model_op(RD_W, 16'hFFFF, 16'h0000, 0, e_lat, e_fault, e_nacc);
    run_op(RD_W, 16'hFFFF, 16'h0000, lat, f, got);
`ifdef MEM_STAGE_MISALIGN_SPLIT_EN
    a0 = (acc_q.size() > abase) ? acc_q[abase] : '0;
    a1 = (acc_q.size() > abase + 1) ? acc_q[abase + 1] : '0;
    n_checks++; if (!got || lat != 3) $display("FAIL split_lat got %0d want 3", lat); else n_pass++;
    n_checks++; if (f !== 1'b0) $display("FAIL split_fault got %b want 0", f); else n_pass++;
    n_checks++; if (rdata_out !== 16'h1234) $display("FAIL split_data got %h want 1234", rdata_out); else n_pass++;
    n_checks++; if (acc_q.size() - abase != 2) $display("FAIL split_nacc got %0d want 2", acc_q.size() - abase); else n_pass++;
    n_checks++;
    if ({a0.addr, a0.be, a1.addr, a1.be} !== {16'hFFFF, 2'b10, 16'h0000, 2'b01})
      $display("FAIL split_bus got %h/%b %h/%b want ffff/10 0000/01", a0.addr, a0.be, a1.addr, a1.be);
    else n_pass++;
`else
    n_checks++; if (!got || lat != 1) $display("FAIL misal_lat got %0d want 1", lat); else n_pass++;
    n_checks++; if (f !== 1'b1) $display("FAIL misal_fault got %b want 1", f); else n_pass++;
    n_checks++; if (rdata_out !== 16'h0000) $display("FAIL misal_data got %h want 0000", rdata_out); else n_pass++;
    n_checks++; if (req_hi_cnt != rbase) $display("FAIL misal_req got %0d want 0", req_hi_cnt - rbase); else n_pass++;
`endif
  endtask

  task automatic test_timeout;
    ack_en = 1'b0;
    rbase = req_hi_cnt;
    run_op(RD_W, 16'h0040, 16'h0000, lat, f, got);
    exp_rdata = '0;
    n_checks++; if (req_hi_cnt - rbase != 4) $display("FAIL tmo_req got %0d want 4", req_hi_cnt - rbase); else n_pass++;
    n_checks++; if (!got || lat != 5) $display("FAIL tmo_lat got %0d want 5", lat); else n_pass++;
    n_checks++; if (f !== 1'b1) $display("FAIL tmo_fault got %b want 1", f); else n_pass++;
    n_checks++; if (rdata_out !== 16'h0000) $display("FAIL tmo_data got %h want 0000", rdata_out); else n_pass++;
    ack_en = 1'b1;
  endtask

  task automatic test_illegal;
    rbase = req_hi_cnt;
    run_op(RD_W | WR_B, 16'h0040, 16'h9999, lat, f, got);
    n_checks++; if (!got || lat != 1) $display("FAIL illegal_lat got %0d want 1", lat); else n_pass++;
    n_checks++; if (f !== 1'b1) $display("FAIL illegal_fault got %b want 1", f); else n_pass++;
    n_checks++; if (req_hi_cnt != rbase) $display("FAIL illegal_req got %0d want 0", req_hi_cnt - rbase); else n_pass++;
    n_checks++; if (rd_byte(16'h0040) !== 8'hEF) $display("FAIL illegal_mem got %h want ef", rd_byte(16'h0040)); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic seen;
    ack_en = 1'b0;
    @(negedge clk);
    {rd_b, rd_w, wr_b, wr_w} = RD_W; addr_in = 16'h0040; en = 1'b1;
    @(posedge clk); #1; en = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (mem_req !== 1'b1) $display("FAIL rstmid_req_pre got %b want 1", mem_req); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL rstmid_req_drop got %b want 0", mem_req); else n_pass++;
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; seen = seen | ready; end
    @(negedge clk) rst_n = 1'b1;
    ack_en = 1'b1;
    repeat (3) begin @(posedge clk); #1; seen = seen | ready | mem_req; end
    n_checks++; if (seen !== 1'b0) $display("FAIL rstmid_ready got %b want 0", seen); else n_pass++;
    exp_rdata = '0;
    ack_wait = 0;
    model_op(RD_W, 16'h0040, 16'h0000, 0, e_lat, e_fault, e_nacc);
    run_op(RD_W, 16'h0040, 16'h0000, lat, f, got);
    n_checks++; if (!got || lat != 2 || f !== 1'b0) $display("FAIL rstmid_next got lat %0d fault %b want 2/0", lat, f); else n_pass++;
    n_checks++; if (rdata_out !== exp_rdata) $display("FAIL rstmid_data got %h want %h", rdata_out, exp_rdata); else n_pass++;
  endtask

  task automatic test_random;
    logic [3:0] fl;
    logic [15:0] a, wd, a_nx;
    logic [CTRL_W-1:0] c;
    int k, r;
    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, 11);
      if (k == 8) fl = 4'b0000;
      else if (k == 9) fl = (4'b0001 << (it % 4)) | (4'b0001 << ((it + 1) % 4));
      else fl = 4'b0001 << (k % 4);
      r = $urandom_range(0, 7);
      a = (r == 0) ? 16'hFFFF : (r == 1) ? 16'hFFFE : 16'h0040 + 16'($urandom_range(0, 31));
      a_nx = a + 16'd1;
      wd = 16'($urandom);
      c = {1'($urandom), 32'($urandom)};
      ctrl_in = c; imm_in = 16'($urandom); pc_in = 16'($urandom);
      ack_wait = $urandom_range(0, 2);
      abase = acc_q.size();
      model_op(fl, a, wd, ack_wait, e_lat, e_fault, e_nacc);
      run_op(fl, a, wd, lat, f, got);
      n_checks++; if (!got || lat != e_lat) $display("FAIL rnd%0d_lat got %0d want %0d", it, lat, e_lat); else n_pass++;
      n_checks++; if (f !== e_fault) $display("FAIL rnd%0d_fault got %b want %b", it, f, e_fault); else n_pass++;
      n_checks++; if (rdata_out !== exp_rdata) $display("FAIL rnd%0d_data got %h want %h", it, rdata_out, exp_rdata); else n_pass++;
      n_checks++;
      if ({ctrl_out, imm_out, pc_out} !== {c, imm_in, pc_in})
        $display("FAIL rnd%0d_pass got %h want %h", it, {ctrl_out, imm_out, pc_out}, {c, imm_in, pc_in});
      else n_pass++;
      n_checks++; if (acc_q.size() - abase != e_nacc) $display("FAIL rnd%0d_nacc got %0d want %0d", it, acc_q.size() - abase, e_nacc); else n_pass++;
      n_checks++;
      if ({rd_byte(a), rd_byte(a_nx)} !== {ref_byte(a), ref_byte(a_nx)})
        $display("FAIL rnd%0d_mem got %h want %h", it, {rd_byte(a), rd_byte(a_nx)}, {ref_byte(a), ref_byte(a_nx)});
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_noop();
    test_aligned_load();
    test_byte_store();
    test_split();
    test_timeout();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage sitting directly downstream of `alu_stage` and upstream of register write-back. It takes the ALU's effective address, store data and memory-control flags, and runs one or two transactions on a 16-bit req/ack data bus. It returns load data where the ALU stage currently reads a constant, and passes the control word, immediate and PC through. It handshakes with `control_unit` in the same en/ready style as `fetch_stage`.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 255: cycles to wait for `mem_ack` before faulting; 0 disables the timeout.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `en` in 1: start pulse from `control_unit`; sampled only in IDLE.
- `ctrl_in` in 33: control word from `alu_stage`; registered and passed through unchanged.
- `imm_in` in 16: immediate; registered and passed through.
- `pc_in` in 16: PC; registered and passed through.
- `addr_in` in 16: effective byte address (ALU result).
- `wdata_in` in 16: store data; byte stores use `[7:0]`.
- `rd_b`, `rd_w`, `wr_b`, `wr_w` in 1 each: memory-op flags, decoded from `ctrl_in`.
- `ready` out 1: one-cycle pulse when the op completes.
- `fault` out 1: valid with `ready`; set for an illegal op or a timeout.
- `rdata_out` out 16: load result; byte loads are zero-extended.
- `ctrl_out` out 33, `imm_out` out 16, `pc_out` out 16: registered pass-through.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 16, `mem_be` out 2, `mem_wdata` out 16: bus request.
  - `mem_be[0]` selects bits `[7:0]` (even address); `mem_be[1]` selects bits `[15:8]` (odd address).
- `mem_ack` in 1, `mem_rdata` in 16: bus response.

## Operation
- States: IDLE, ACC1, ACC2, DONE.
- IDLE, `en`=1:
  - Capture all inputs.
  - No flag set: go to DONE with no bus access.
  - Exactly one flag set: go to ACC1.
  - More than one flag set: go to DONE with `fault`=1 and no bus access.
- ACC1: drive the first access with `mem_req`=1.
  - On `mem_ack`: latch lane data.
  - Go to ACC2 if the access is split, otherwise to DONE.
- ACC2: second access of a split word. On `mem_ack`, go to DONE.
- DONE: pulse `ready` for one cycle, return to IDLE.
- Byte ordering is little-endian.
- Byte access at address A: `mem_be` = 01 if A even, 10 if A odd.
  - Store: the byte is replicated onto both lanes.
  - Load: the selected lane goes to `rdata_out[7:0]`; `[15:8]`=0.
- Aligned word (A even): `mem_be`=11, single access.
- Misaligned word (A odd), split enabled:
  - ACC1: address A, `be`=10, low byte on `[15:8]`.
  - ACC2: address A+1 (16-bit wrap, 0xFFFF→0x0000), `be`=01, high byte on `[7:0]`.
- `mem_addr` always carries the full byte address.
- Timeout: a counter runs while `mem_req`=1 with no ack.
  - When it reaches `ACK_TIMEOUT`, drop the request, go to DONE with `fault`=1, and set `rdata_out`=0.
- `rdata_out` holds its value until the next completing load.

## Timing
- Reset values:
  - `mem_req`, `mem_we`, `ready`, `fault` = 0.
  - `mem_be` = 00.
  - All data, address and pass-through outputs = 0.
  - State = IDLE.
- `en` high at edge N:
  - No-op: `ready` high during cycle N+1.
  - Single access: `mem_req` high from N+1.
- Ack at edge M ends the access; `mem_req` is low in the cycle after M.
  - Single access: `ready` is high in that cycle.
  - Split access: ACC2's `mem_req` rises in that cycle, with no idle gap.
- Zero-wait memory (ack in the first request cycle): a single access gives `ready` at N+2, a split access at N+3.
- Bus signals are held stable while `mem_req`=1 and ack is pending.
- `ctrl_out`, `imm_out`, `pc_out` update at edge N and are stable through `ready`.
- `en` outside IDLE is ignored. `mem_ack` outside ACC1/ACC2 is ignored.
- `rst_n` low mid-access:
  - `mem_req` drops immediately (asynchronously).
  - No `ready` is produced; the transaction is abandoned.

## Configuration
- `MEM_STAGE_MISALIGN_SPLIT_EN` defined: misaligned word accesses split into two byte accesses, as above.
- Not defined: a misaligned word access goes IDLE→DONE with `fault`=1, no bus access, `rdata_out`=0; ACC2 is not synthesised.

## Structure
- `nqcpu_pkg` holds:
  - the state enum;
  - `CTRL_W`=33;
  - byte-lane constants `BE_LO`=01, `BE_HI`=10, `BE_W`=11.
- Sub-module `mem_lane_align`: combinational. It maps (address LSB, byte/word, phase) to `mem_be` and the store lane data, and selects load lanes into the result. It is reused by a future fetch bus arbiter.

## Test plan
- No-op: `en` with all flags 0, `pc_in`=0x0010 → `ready` at N+1, `fault`=0, `pc_out`=0x0010, `mem_req` never high.
- Aligned word load: `addr_in`=0x0040, memory returns 0xBEEF after 2 wait cycles → one request with `be`=11; `rdata_out`=0xBEEF.
- Byte store at 0x0041, `wdata_in`=0x12A5 → `mem_we`=1, `be`=10, `mem_wdata`=0xA5A5, single access.
- Split word load at 0xFFFF, memory 0xFFFE=0x3400, 0x0000=0x0012, with macro defined → accesses 0xFFFF/`be`10 then 0x0000/`be`01, `rdata_out`=0x1234. Without the macro → `fault`=1, no request.
- Timeout: `ACK_TIMEOUT`=4, no ack → `mem_req` high 4 cycles, then `ready` with `fault`=1; `rd_w`+`wr_b` both set → `fault`=1, no bus access.
- Reset mid-access: `rst_n` low while `mem_req`=1 → `mem_req` low immediately, state IDLE, no `ready`; the next `en` works normally.
